banco_operandos: RTL and testbench
==================================

# banco_operandos

Operand-fetch stage that sits directly upstream of the ALU. It holds the 32x32 general register file and selects the second operand, either a register or a sign-extended immediate. It then registers Ope1, Ope2 and AluOp into a one-deep pipeline latch with stall, flush and valid control, so the ALU sees stable, registered operands. Write-back from downstream enters through a single write port with same-cycle bypass.

## Interface
Parameters:
- NREG, 32: number of registers; register 0 is hardwired to zero.
- ANCHO, 32: data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ValidoIn  in  1  upstream presents a valid instruction this cycle.
- RegLeer1  in  5  source register index for Ope1.
- RegLeer2  in  5  source register index for Ope2 when UsarInm=0.
- Inmediato  in  16  immediate, sign-extended to 32 bits.
- UsarInm  in  1  1: Ope2 = sext(Inmediato); 0: Ope2 = register RegLeer2.
- AluOpIn  in  3  ALU operation code, passed through unchanged (000 AND, 001 OR, 010 SUMA, 110 RESTA, 111 MAYORQ).
- RegDestIn  in  5  destination index, carried alongside for write-back.
- Stall  in  1  hold the output latch.
- Flush  in  1  replace the latch contents with a bubble.
- EscEn  in  1  write-back enable.
- RegEsc  in  5  write-back index.
- DatoEsc  in  32  write-back data.
- Ope1  out  32  registered first ALU operand.
- Ope2  out  32  registered second ALU operand.
- AluOp  out  3  registered operation code.
- RegDest  out  5  registered destination index.
- Valido  out  1  latch holds a valid instruction.

## Operation
- Register file: NREG x ANCHO, two combinational read ports, one synchronous write port.
- Writes occur when EscEn=1 and RegEsc!=0. Writes to index 0 are ignored; reads of index 0 always return 0.
- Bypass: if EscEn=1, RegEsc!=0 and RegEsc equals a read index in the same cycle, that read returns DatoEsc instead of the stored value. The bypass applies independently to both ports.
- Operand select: Ope2 next value is sext(Inmediato) if UsarInm=1, otherwise the port-2 read value. Sign extension copies bit 15 into bits 31:16.
- Latch update priority, evaluated per rising edge:
  1. rst
  2. Flush
  3. Stall
  4. normal
- rst: all registers cleared to 0. Ope1=Ope2=0, AluOp=000, RegDest=0, Valido=0.
- Flush (with rst=0): latch loads a bubble (all outputs 0, Valido=0), even if Stall=1.
- Stall (with rst=0, Flush=0): latch holds all outputs unchanged.
- Normal, ValidoIn=1: latch loads the selected operands, AluOpIn and RegDestIn, and sets Valido=1.
- Normal, ValidoIn=0: latch loads a bubble (all zeros, Valido=0).
- Register-file writes are independent of Stall and Flush. They occur on every edge with rst=0 and a valid write.
- Write and rst asserted together: rst wins and the register stays 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- A write at edge N is visible to reads in the same cycle before edge N (via bypass) and from storage after edge N.
- Stall held for k cycles: outputs constant for k cycles. The first non-stalled edge loads the current inputs, including any writes that occurred during the stall.
- Reset applied mid-stream: outputs are zero and Valido=0 after the first edge with rst=1. All registers read 0 afterwards until rewritten.
- All outputs are driven by flops only; there is no combinational path from input to output.

## Test plan
- Reset, then write R5=0x0000_0007 and R6=0x0000_0003. Next cycle: RegLeer1=5, RegLeer2=6, UsarInm=0, AluOpIn=110, ValidoIn=1 -> after one edge Ope1=7, Ope2=3, AluOp=110, Valido=1.
- Immediate: R1=0x10, Inmediato=0xFFFE, UsarInm=1 -> Ope2=0xFFFF_FFFE. Inmediato=0x7FFF -> Ope2=0x0000_7FFF.
- Bypass: in the same cycle, EscEn=1, RegEsc=4, DatoEsc=0xDEAD_BEEF and RegLeer1=4 -> Ope1=0xDEAD_BEEF. Write to R0 of 0x1234 with RegLeer1=0 -> Ope1=0.
- Stall/flush: load a valid op, then Stall=1 for 3 cycles while inputs change -> outputs unchanged. Stall=1 and Flush=1 together -> all outputs 0, Valido=0.
- Reset mid-operation: after writes to R1..R3, assert rst for one edge -> outputs 0 and Valido=0. Subsequent reads of R1..R3 return 0.
- Bubble: ValidoIn=0 with Stall=0 -> Valido=0 and Ope1=Ope2=0, AluOp=000.

Source files
------------

// File: rtl/banco_operandos.sv
// Operand fetch: 32x32 register file with write bypass, immediate select, one-deep output latch.
// Latency 1 cycle; Stall holds the latch, Flush (over Stall) loads a bubble, no ready path upstream.
module banco_operandos #(
  parameter int NREG  = 32,
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidoIn,
  input  logic [4:0]       RegLeer1,
  input  logic [4:0]       RegLeer2,
  input  logic [15:0]      Inmediato,
  input  logic             UsarInm,
  input  logic [2:0]       AluOpIn,
  input  logic [4:0]       RegDestIn,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             EscEn,
  input  logic [4:0]       RegEsc,
  input  logic [ANCHO-1:0] DatoEsc,
  output logic [ANCHO-1:0] Ope1,
  output logic [ANCHO-1:0] Ope2,
  output logic [2:0]       AluOp,
  output logic [4:0]       RegDest,
  output logic             Valido
);

  logic [ANCHO-1:0] banco [NREG];
  logic             esc_ok;
  logic [ANCHO-1:0] lect1;
  logic [ANCHO-1:0] lect2;
  logic [ANCHO-1:0] inm_ext;
  logic [ANCHO-1:0] ope2_sig;

  assign esc_ok = EscEn && (RegEsc != 5'd0);

  // Index 0 is forced to zero here so a write-back aimed at it can never bypass through.
  always_comb begin
    lect1 = '0;
    lect2 = '0;
    if (RegLeer1 != 5'd0) begin
      if (esc_ok && (RegEsc == RegLeer1)) lect1 = DatoEsc;
      else                                lect1 = banco[RegLeer1];
    end
    if (RegLeer2 != 5'd0) begin
      if (esc_ok && (RegEsc == RegLeer2)) lect2 = DatoEsc;
      else                                lect2 = banco[RegLeer2];
    end
  end

  assign inm_ext  = {{(ANCHO-16){Inmediato[15]}}, Inmediato};
  assign ope2_sig = UsarInm ? inm_ext : lect2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) banco[i] <= '0;
    end else if (esc_ok) begin
      banco[RegEsc] <= DatoEsc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || Flush || (!Stall && !ValidoIn)) begin
      Ope1    <= '0;
      Ope2    <= '0;
      AluOp   <= 3'b000;
      RegDest <= 5'd0;
      Valido  <= 1'b0;
    end else if (!Stall) begin
      Ope1    <= lect1;
      Ope2    <= ope2_sig;
      AluOp   <= AluOpIn;
      RegDest <= RegDestIn;
      Valido  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_banco_operandos.sv
// Directed bench for banco_operandos with hand-computed expected values.
module tb_banco_operandos;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidoIn;
  logic [4:0]  RegLeer1;
  logic [4:0]  RegLeer2;
  logic [15:0] Inmediato;
  logic        UsarInm;
  logic [2:0]  AluOpIn;
  logic [4:0]  RegDestIn;
  logic        Stall;
  logic        Flush;
  logic        EscEn;
  logic [4:0]  RegEsc;
  logic [31:0] DatoEsc;
  logic [31:0] Ope1;
  logic [31:0] Ope2;
  logic [2:0]  AluOp;
  logic [4:0]  RegDest;
  logic        Valido;

  int pruebas = 0;
  int fallos  = 0;

  banco_operandos #(.NREG(32), .ANCHO(32)) dut (
    .clk(clk), .rst(rst), .ValidoIn(ValidoIn), .RegLeer1(RegLeer1), .RegLeer2(RegLeer2),
    .Inmediato(Inmediato), .UsarInm(UsarInm), .AluOpIn(AluOpIn), .RegDestIn(RegDestIn),
    .Stall(Stall), .Flush(Flush), .EscEn(EscEn), .RegEsc(RegEsc), .DatoEsc(DatoEsc),
    .Ope1(Ope1), .Ope2(Ope2), .AluOp(AluOp), .RegDest(RegDest), .Valido(Valido)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    pruebas++;
    if (obs !== exp) begin
      fallos++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  task automatic escribir(input logic [4:0] idx, input logic [31:0] dato);
    EscEn = 1'b1; RegEsc = idx; DatoEsc = dato;
    paso();
    EscEn = 1'b0;
  endtask

  task automatic check_salidas(input string tag, input logic [31:0] o1, input logic [31:0] o2,
                               input logic [2:0] op, input logic [4:0] rd, input logic v);
    check({tag, ".ope1"}, Ope1, o1);
    check({tag, ".ope2"}, Ope2, o2);
    check({tag, ".aluop"}, {29'd0, AluOp}, {29'd0, op});
    check({tag, ".regdest"}, {27'd0, RegDest}, {27'd0, rd});
    check({tag, ".valido"}, {31'd0, Valido}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b1; ValidoIn = 1'b0; RegLeer1 = '0; RegLeer2 = '0; Inmediato = '0; UsarInm = 1'b0;
    AluOpIn = '0; RegDestIn = '0; Stall = 1'b0; Flush = 1'b0; EscEn = 1'b0; RegEsc = '0; DatoEsc = '0;
    #2;
    paso();
    paso();
    check_salidas("reset", 32'h0, 32'h0, 3'b000, 5'd0, 1'b0);
    rst = 1'b0;

    // Basic register-register fetch
    escribir(5'd5, 32'h0000_0007);
    escribir(5'd6, 32'h0000_0003);
    RegLeer1 = 5'd5; RegLeer2 = 5'd6; UsarInm = 1'b0; AluOpIn = 3'b110; RegDestIn = 5'd9; ValidoIn = 1'b1;
    paso();
    check_salidas("resta", 32'h7, 32'h3, 3'b110, 5'd9, 1'b1);

    // Immediate sign extension
    escribir(5'd1, 32'h0000_0010);
    RegLeer1 = 5'd1; UsarInm = 1'b1; Inmediato = 16'hFFFE; AluOpIn = 3'b010; RegDestIn = 5'd2;
    paso();
    check_salidas("inm_neg", 32'h10, 32'hFFFF_FFFE, 3'b010, 5'd2, 1'b1);
    Inmediato = 16'h7FFF;
    paso();
    check("inm_pos.ope2", Ope2, 32'h0000_7FFF);

    // Same-cycle bypass on both ports, then storage read
    UsarInm = 1'b0; RegLeer1 = 5'd4; RegLeer2 = 5'd4;
    EscEn = 1'b1; RegEsc = 5'd4; DatoEsc = 32'hDEAD_BEEF;
    paso();
    EscEn = 1'b0;
    check("bypass.ope1", Ope1, 32'hDEAD_BEEF);
    check("bypass.ope2", Ope2, 32'hDEAD_BEEF);
    RegLeer2 = 5'd6;
    paso();
    check("stored.ope1", Ope1, 32'hDEAD_BEEF);
    check("stored.ope2", Ope2, 32'h3);

    // Register 0 ignores writes and never bypasses
    RegLeer1 = 5'd0; RegLeer2 = 5'd0;
    EscEn = 1'b1; RegEsc = 5'd0; DatoEsc = 32'h0000_1234;
    paso();
    EscEn = 1'b0;
    check("r0_bypass.ope1", Ope1, 32'h0);
    check("r0_bypass.ope2", Ope2, 32'h0);
    paso();
    check("r0_stored.ope1", Ope1, 32'h0);

    // Stall holds outputs while inputs and storage change
    RegLeer1 = 5'd5; RegLeer2 = 5'd6; AluOpIn = 3'b001; RegDestIn = 5'd3;
    paso();
    check_salidas("pre_stall", 32'h7, 32'h3, 3'b001, 5'd3, 1'b1);
    Stall = 1'b1;
    EscEn = 1'b1; RegEsc = 5'd5; DatoEsc = 32'h0000_0055;
    for (int k = 0; k < 3; k++) begin
      RegLeer1 = 5'd4; RegLeer2 = 5'd1; AluOpIn = 3'b111; RegDestIn = 5'd20 + 5'(k);
      ValidoIn = (k != 1);
      paso();
      EscEn = 1'b0;
      check_salidas($sformatf("stall%0d", k), 32'h7, 32'h3, 3'b001, 5'd3, 1'b1);
    end
    Stall = 1'b0; ValidoIn = 1'b1; RegLeer1 = 5'd5; RegLeer2 = 5'd6; AluOpIn = 3'b000; RegDestIn = 5'd7;
    paso();
    check_salidas("post_stall", 32'h55, 32'h3, 3'b000, 5'd7, 1'b1);

    // Flush beats Stall
    Stall = 1'b1; Flush = 1'b1;
    paso();
    check_salidas("flush_stall", 32'h0, 32'h0, 3'b000, 5'd0, 1'b0);
    Stall = 1'b0; Flush = 1'b0; AluOpIn = 3'b111; RegDestIn = 5'd12;
    paso();
    check_salidas("reload", 32'h55, 32'h3, 3'b111, 5'd12, 1'b1);

    // Bubble when upstream is idle
    ValidoIn = 1'b0;
    paso();
    check_salidas("bubble", 32'h0, 32'h0, 3'b000, 5'd0, 1'b0);

    // Reset mid-stream clears storage; a write during reset is lost
    escribir(5'd1, 32'd11);
    escribir(5'd2, 32'd22);
    escribir(5'd3, 32'd33);
    ValidoIn = 1'b1; RegLeer1 = 5'd1; RegLeer2 = 5'd2; AluOpIn = 3'b010; RegDestIn = 5'd8;
    paso();
    check_salidas("pre_rst", 32'd11, 32'd22, 3'b010, 5'd8, 1'b1);
    rst = 1'b1; EscEn = 1'b1; RegEsc = 5'd7; DatoEsc = 32'd77;
    paso();
    rst = 1'b0; EscEn = 1'b0;
    check_salidas("rst_mid", 32'h0, 32'h0, 3'b000, 5'd0, 1'b0);
    paso();
    check_salidas("post_rst12", 32'h0, 32'h0, 3'b010, 5'd8, 1'b1);
    RegLeer1 = 5'd3; RegLeer2 = 5'd7;
    paso();
    check("post_rst3.ope1", Ope1, 32'h0);
    check("post_rst7.ope2", Ope2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", pruebas, fallos);
    $finish;
  end

endmodule
